// File: rtl/stack_ctrl.sv
// Stack controller: sequences push/pop (single and double word) against an
// external stack pointer and a single-port stack memory.
module stack_ctrl #(
    parameter logic [15:0] SC_LIMIT = 16'hFF00
) (
    input  logic        SC_clk,
    input  logic        SC_rst,
    input  logic        SC_req,
    input  logic [1:0]  SC_op,
    input  logic [15:0] SC_wdata0,
    input  logic [15:0] SC_wdata1,
    input  logic [15:0] SC_sp,
    output logic        SC_sp_inc,
    output logic        SC_sp_dec,
    output logic [15:0] SC_mem_addr,
    output logic [15:0] SC_mem_wdata,
    output logic        SC_mem_we,
    output logic        SC_mem_re,
    input  logic [15:0] SC_mem_rdata,
    output logic        SC_ready,
    output logic        SC_done,
    output logic        SC_err,
    output logic [15:0] SC_rdata0,
    output logic [15:0] SC_rdata1
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  op_q;
    logic [15:0] wd0_q, wd1_q;
    logic [15:0] rd0_q, rd1_q;
    logic        second_q, second_nx;

    logic [16:0] sp_ext, n_ext;
    logic        overflow, underflow, illegal;

    // Widened to 17 bits so neither bound check can wrap.
    always_comb begin
        sp_ext    = {1'b0, SC_sp};
        n_ext     = SC_op[1] ? 17'd2 : 17'd1;
        overflow  = sp_ext < ({1'b0, SC_LIMIT} + n_ext - 17'd1);
        underflow = (17'h0FFFF - sp_ext) < n_ext;
        illegal   = SC_op[0] ? underflow : overflow;
    end

    always_comb begin
        state_nx     = state;
        second_nx    = second_q;
        SC_ready     = 1'b0;
        SC_done      = 1'b0;
        SC_err       = 1'b0;
        SC_mem_we    = 1'b0;
        SC_mem_re    = 1'b0;
        SC_sp_inc    = 1'b0;
        SC_sp_dec    = 1'b0;
        SC_mem_addr  = '0;
        SC_mem_wdata = '0;

        case (state)
            S_IDLE: begin
                SC_ready  = 1'b1;
                second_nx = 1'b0;
                if (SC_req) begin
                    if (illegal)
                        state_nx = S_ERR;
                    else if (SC_op[0])
                        state_nx = S_RD;
                    else
                        state_nx = S_WR;
                end
            end
            S_WR: begin
                SC_mem_we    = 1'b1;
                SC_sp_inc    = 1'b1;
                SC_mem_addr  = SC_sp;
                SC_mem_wdata = second_q ? wd1_q : wd0_q;
                if (op_q[1] && !second_q) begin
                    second_nx = 1'b1;
                    state_nx  = S_WR;
                end else begin
                    state_nx  = S_DONE;
                end
            end
            S_RD: begin
                SC_mem_re   = 1'b1;
                SC_sp_dec   = 1'b1;
                SC_mem_addr = SC_sp + 16'd1;
                state_nx    = S_WAIT;
            end
            S_WAIT: begin
                if (op_q[1] && !second_q) begin
                    second_nx = 1'b1;
                    state_nx  = S_RD;
                end else begin
                    state_nx  = S_DONE;
                end
            end
            S_DONE: begin
                SC_done  = 1'b1;
                state_nx = S_IDLE;
            end
            S_ERR: begin
                SC_done  = 1'b1;
                SC_err   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        // Reset silences the bus in the same cycle so an aborted op issues no further strobe.
        if (SC_rst) begin
            SC_ready     = 1'b0;
            SC_done      = 1'b0;
            SC_err       = 1'b0;
            SC_mem_we    = 1'b0;
            SC_mem_re    = 1'b0;
            SC_sp_inc    = 1'b0;
            SC_sp_dec    = 1'b0;
            SC_mem_addr  = '0;
            SC_mem_wdata = '0;
        end
    end

    always_ff @(posedge SC_clk) begin
        if (SC_rst) begin
            state    <= S_IDLE;
            second_q <= 1'b0;
            op_q     <= '0;
            wd0_q    <= '0;
            wd1_q    <= '0;
            rd0_q    <= '0;
            rd1_q    <= '0;
        end else begin
            state    <= state_nx;
            second_q <= second_nx;
            if (state == S_IDLE && SC_req) begin
                op_q  <= SC_op;
                wd0_q <= SC_wdata0;
                wd1_q <= SC_wdata1;
            end
            // POP2 fetches the top word first; it belongs in rdata1.
            if (state == S_WAIT) begin
                if (op_q[1] && !second_q)
                    rd1_q <= SC_mem_rdata;
                else
                    rd0_q <= SC_mem_rdata;
            end
        end
    end

    assign SC_rdata0 = rd0_q;
    assign SC_rdata1 = rd1_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: external SP/memory environment, transaction-level
// expectation model checked every cycle, plus directed literal checks.
module tb_stack_ctrl;

    localparam logic [15:0] LIM = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst, req;
    logic [1:0]  op;
    logic [15:0] w0, w1, sp, mem_rdata;
    logic        sp_inc, sp_dec, mem_we, mem_re, ready, done, err;
    logic [15:0] mem_addr, mem_wdata, rd0, rd1;

    always #5 clk = ~clk;

    stack_ctrl #(.SC_LIMIT(LIM)) dut (
        .SC_clk(clk), .SC_rst(rst), .SC_req(req), .SC_op(op),
        .SC_wdata0(w0), .SC_wdata1(w1), .SC_sp(sp),
        .SC_sp_inc(sp_inc), .SC_sp_dec(sp_dec),
        .SC_mem_addr(mem_addr), .SC_mem_wdata(mem_wdata),
        .SC_mem_we(mem_we), .SC_mem_re(mem_re), .SC_mem_rdata(mem_rdata),
        .SC_ready(ready), .SC_done(done), .SC_err(err),
        .SC_rdata0(rd0), .SC_rdata1(rd1)
    );

    // Environment: stack pointer register and stack memory
    logic        sp_ld;
    logic [15:0] sp_ld_val;
    logic [15:0] env_mem [0:65535];
    int          wr_cnt = 0;
    int          done_cnt = 0;

    always @(posedge clk) begin
        if (sp_ld)       sp <= sp_ld_val;
        else if (sp_inc) sp <= sp - 16'd1;
        else if (sp_dec) sp <= sp + 16'd1;
        if (mem_we) env_mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= env_mem[mem_addr];
        if (mem_we) wr_cnt <= wr_cnt + 1;
        if (done)   done_cnt <= done_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expectation model: each accepted request expands into a per-cycle script
    typedef struct packed {
        logic        ready, done, err, we, re, inc, dec;
        logic [15:0] addr, wdata, rd0, rd1;
    } exp_t;

    exp_t        cur;
    exp_t        q[$];
    logic [15:0] m_mem [0:65535];
    logic [15:0] h0, h1;
    bit          live = 0;

    function automatic exp_t idle_of(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e       = '0;
        e.ready = 1'b1;
        e.rd0   = a;
        e.rd1   = b;
        return e;
    endfunction

    task automatic build(input logic [1:0] o, input logic [15:0] s,
                         input logic [15:0] a, input logic [15:0] b);
        int          n, spi;
        exp_t        base, e;
        logic [15:0] r0, r1, word;
        n    = o[1] ? 2 : 1;
        spi  = int'(s);
        base = idle_of(h0, h1);
        base.ready = 1'b0;
        if (o[0] == 1'b0 ? (spi < int'(LIM) + n - 1) : (65535 - spi < n)) begin
            e = base; e.done = 1'b1; e.err = 1'b1;
            q.push_back(e);
            return;
        end
        if (o[0] == 1'b0) begin
            for (int k = 0; k < n; k++) begin
                e = base; e.we = 1'b1; e.inc = 1'b1;
                e.addr  = 16'(spi - k);
                e.wdata = (k == 0) ? a : b;
                q.push_back(e);
            end
            e = base; e.done = 1'b1;
            q.push_back(e);
        end else begin
            r0 = h0; r1 = h1;
            for (int k = 0; k < n; k++) begin
                word = m_mem[16'(spi + 1 + k)];
                e = base; e.re = 1'b1; e.dec = 1'b1;
                e.addr = 16'(spi + 1 + k); e.rd0 = r0; e.rd1 = r1;
                q.push_back(e);
                e = base; e.rd0 = r0; e.rd1 = r1;
                q.push_back(e);
                if (n == 2 && k == 0) r1 = word; else r0 = word;
            end
            e = base; e.done = 1'b1; e.rd0 = r0; e.rd1 = r1;
            q.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            h0   = '0;
            h1   = '0;
            cur  = idle_of('0, '0);
            live = 1;
        end else begin
            if (cur.we) m_mem[cur.addr] = cur.wdata;
            h0 = cur.rd0;
            h1 = cur.rd1;
            if (cur.ready && req) build(op, sp, w0, w1);
            cur = (q.size() > 0) ? q.pop_front() : idle_of(h0, h1);
        end
    end

    always @(negedge clk) begin
        if (live) begin
            if (rst) begin
                chk("rst_quiet", {10'b0, done, err, mem_we, mem_re, sp_inc, sp_dec}, 16'h0);
            end else begin
                chk("ready", 16'(ready),  16'(cur.ready));
                chk("done",  16'(done),   16'(cur.done));
                chk("err",   16'(err),    16'(cur.err));
                chk("we",    16'(mem_we), 16'(cur.we));
                chk("re",    16'(mem_re), 16'(cur.re));
                chk("inc",   16'(sp_inc), 16'(cur.inc));
                chk("dec",   16'(sp_dec), 16'(cur.dec));
                if (cur.we || cur.re) chk("addr", mem_addr, cur.addr);
                if (cur.we) chk("wdata", mem_wdata, cur.wdata);
                chk("rdata0", rd0, cur.rd0);
                chk("rdata1", rd1, cur.rd1);
            end
        end
    end

    // Directed stimulus
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_sp(input logic [15:0] v);
        sp_ld     = 1'b1;
        sp_ld_val = v;
        step();
        sp_ld     = 1'b0;
    endtask

    // Inputs are scrambled after acceptance; the DUT must ignore them.
    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        req = 1'b1; op = o; w0 = a; w1 = b;
        step();
        req = 1'b0; op = ~o; w0 = ~a; w1 = ~b;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (done !== 1'b1 && lat < 12) begin
            step();
            lat++;
        end
        if (done !== 1'b1) chk("done_timeout", 16'(done), 16'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, wbase, dbase;
        rst = 1'b1; req = 1'b0; op = 2'b00; w0 = '0; w1 = '0;
        sp_ld = 1'b1; sp_ld_val = 16'hFFFF;
        repeat (3) step();
        rst = 1'b0; sp_ld = 1'b0;
        #1;
        chk("rst_ready", 16'(ready), 16'h1);
        chk("rst_done",  16'(done),  16'h0);
        chk("rst_addr",  mem_addr,   16'h0000);
        chk("rst_wdata", mem_wdata,  16'h0000);
        chk("rst_rd0",   rd0,        16'h0000);
        chk("rst_rd1",   rd1,        16'h0000);

        // PUSH from empty
        issue(2'b00, 16'h1234, 16'h0);
        chk("c1_we",    16'(mem_we), 16'h1);
        chk("c1_addr",  mem_addr,    16'hFFFF);
        chk("c1_wdata", mem_wdata,   16'h1234);
        chk("c1_inc",   16'(sp_inc), 16'h1);
        wait_done(1, lat);
        chk("c1_lat", 16'(lat), 16'd2);
        chk("c1_err", 16'(err), 16'h0);
        step();

        // POP from empty -> underflow
        set_sp(16'hFFFF);
        issue(2'b01, 16'h0, 16'h0);
        wait_done(1, lat);
        chk("c2_lat", 16'(lat), 16'd1);
        chk("c2_err", 16'(err), 16'h1);
        step();

        // PUSH2 then POP2 round trip
        set_sp(16'hFFFF);
        issue(2'b10, 16'hAAAA, 16'hBBBB);
        chk("c3_a0", mem_addr,  16'hFFFF);
        chk("c3_d0", mem_wdata, 16'hAAAA);
        step();
        chk("c3_we1", 16'(mem_we), 16'h1);
        chk("c3_a1",  mem_addr,    16'hFFFE);
        chk("c3_d1",  mem_wdata,   16'hBBBB);
        wait_done(2, lat);
        chk("c3_plat", 16'(lat), 16'd3);
        step();
        issue(2'b11, 16'h0, 16'h0);
        chk("c3_re0",  16'(mem_re), 16'h1);
        chk("c3_ra0",  mem_addr,    16'hFFFE);
        chk("c3_dec0", 16'(sp_dec), 16'h1);
        step();
        step();
        chk("c3_ra1",  mem_addr, 16'hFFFF);
        chk("c3_rd1e", rd1,      16'hBBBB);
        wait_done(3, lat);
        chk("c3_lat",  16'(lat),  16'd5);
        chk("c3_rd1",  rd1,       16'hBBBB);
        chk("c3_rd0",  rd0,       16'hAAAA);
        chk("c3_model_rd0", cur.rd0, 16'hAAAA);
        chk("c3_model_rd1", cur.rd1, 16'hBBBB);
        step();
        chk("c3_sp", sp, 16'hFFFF);

        // Overflow boundary at the limit
        set_sp(16'hFF00);
        issue(2'b10, 16'h1, 16'h2);
        wait_done(1, lat);
        chk("c4_lat2", 16'(lat), 16'd1);
        chk("c4_err2", 16'(err), 16'h1);
        step();
        issue(2'b00, 16'hCAFE, 16'h0);
        chk("c4_addr", mem_addr, 16'hFF00);
        wait_done(1, lat);
        chk("c4_err1", 16'(err), 16'h0);
        step();
        chk("c4_sp", sp, 16'hFEFF);

        // Underflow boundary: one word left
        set_sp(16'hFFFE);
        issue(2'b11, 16'h0, 16'h0);
        wait_done(1, lat);
        chk("ub_err2", 16'(err), 16'h1);
        step();
        issue(2'b01, 16'h0, 16'h0);
        chk("ub_addr", mem_addr, 16'hFFFF);
        wait_done(1, lat);
        chk("ub_lat", 16'(lat), 16'd3);
        chk("ub_err", 16'(err), 16'h0);
        chk("ub_rd0", rd0,      16'hAAAA);
        chk("ub_rd1", rd1,      16'hBBBB);
        step();
        chk("ub_sp", sp, 16'hFFFF);

        // Reset in the middle of PUSH2
        set_sp(16'hFFFF);
        wbase = wr_cnt;
        issue(2'b10, 16'h1111, 16'h2222);
        step();
        rst = 1'b1;
        #1;
        chk("c5_we_rst", 16'(mem_we), 16'h0);
        step();
        rst = 1'b0;
        #1;
        chk("c5_ready", 16'(ready), 16'h1);
        chk("c5_done",  16'(done),  16'h0);
        chk("c5_rd0",   rd0,        16'h0000);
        chk("c5_writes", 16'(wr_cnt - wbase), 16'd1);
        chk("c5_sp", sp, 16'hFFFE);

        // Request held high across completion
        set_sp(16'hFFFF);
        wbase = wr_cnt;
        dbase = done_cnt;
        req = 1'b1; op = 2'b00; w0 = 16'h5555; w1 = 16'h0;
        repeat (6) step();
        req = 1'b0;
        repeat (3) step();
        chk("c6_writes", 16'(wr_cnt - wbase),   16'd2);
        chk("c6_dones",  16'(done_cnt - dbase), 16'd2);
        chk("c6_sp",     sp,                    16'hFFFD);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001: Parameter SC_LIMIT, default 16'hFF00, lowest legal stack address; the stack occupies SC_LIMIT..16'hFFFF.
REQ-002: SC_clk  in  1  single clock; all state changes on its rising edge.
REQ-003: SC_rst  in  1  reset, synchronous and active-high.
REQ-004: SC_req  in  1  operation request; sampled only while SC_ready=1.
REQ-005: SC_op  in  2  operation: 00 PUSH, 01 POP, 10 PUSH2, 11 POP2.
REQ-006: SC_wdata0, SC_wdata1  in  16 each  push data; sampled on acceptance.
REQ-007: SC_sp  in  16  current stack pointer (next free slot; 16'hFFFF = empty).
REQ-008: SC_sp_inc  out  1  drives the pointer's decrement-on-push input (SP-1).
REQ-009: SC_sp_dec  out  1  drives the pointer's increment-on-pop input (SP+1).
REQ-010: SC_mem_addr  out  16, SC_mem_wdata  out  16, SC_mem_we  out  1, SC_mem_re  out  1: stack memory port.
REQ-011: SC_mem_rdata  in  16  read data, valid the cycle after SC_mem_re.
REQ-012: SC_ready  out  1  high only in IDLE.
REQ-013: SC_done  out  1  one-cycle completion pulse.
REQ-014: SC_err  out  1  valid with SC_done; 1 = overflow/underflow, operation not performed.
REQ-015: SC_rdata0, SC_rdata1  out  16 each  popped data, registered, held until the next pop completes.

Function
REQ-016: States IDLE, CHECK-free accept, WR, RD, WAIT, DONE, ERR; the FSM accepts in IDLE when SC_req=1 and registers op and wdata.
REQ-017: The legality check uses 17-bit arithmetic on the SC_sp value present in the accept cycle; n = 1 for PUSH/POP and n = 2 for PUSH2/POP2.
REQ-018: A push is overflow when SC_sp < SC_LIMIT + n - 1; a pop is underflow when 16'hFFFF - SC_sp < n.
REQ-019: An illegal request goes to ERR: SC_done=1 and SC_err=1 at T+1, with no memory access, no SP strobe, and SC_rdata unchanged.
REQ-020: A WR cycle drives SC_mem_addr=SC_sp, SC_mem_we=1 and SC_sp_inc=1 together.
REQ-021: PUSH writes wdata0 at T+1 and pulses done at T+2; PUSH2 writes wdata0 at T+1, wdata1 at T+2 (the address is the already-updated SC_sp) and pulses done at T+3.
REQ-022: An RD cycle drives SC_mem_addr=SC_sp+1 (16-bit), SC_mem_re=1 and SC_sp_dec=1 together; in the WAIT cycle the FSM registers SC_mem_rdata.
REQ-023: POP uses RD at T+1, WAIT at T+2 (captures into rdata0) and pulses done at T+3.
REQ-024: POP2 first captures rdata1 (RD T+1, WAIT T+2), then rdata0 (RD T+3, WAIT T+4), and pulses done at T+5, so PUSH2 followed by POP2 returns identical words.
REQ-025: SC_sp_inc and SC_sp_dec are never high in the same cycle; SC_mem_we and SC_mem_re are never high in the same cycle.
REQ-026: In DONE and ERR the FSM pulses SC_done for one cycle and returns to IDLE; SC_ready=0 in that cycle, so a request there is ignored.
REQ-027: SC_req while SC_ready=0 is ignored and is not queued.
REQ-028: Boundary cases: a push exactly filling to SC_sp=SC_LIMIT-1 is legal; a pop bringing SC_sp back to 16'hFFFF is legal.
REQ-029: The block never wraps SC_sp; the legality checks prevent wrap.
REQ-030: SC_op values take effect only on acceptance; op changes mid-operation have no effect.

Reset
REQ-031: While SC_rst=1 at a clock edge, the FSM goes to IDLE and SC_done, SC_err, SC_sp_inc, SC_sp_dec, SC_mem_we and SC_mem_re are 0.
REQ-032: Under reset, SC_mem_addr, SC_mem_wdata, SC_rdata0 and SC_rdata1 are 16'h0000 and SC_ready=1 from the cycle after reset.
REQ-033: Reset has priority over a request in the same cycle.
REQ-034: Reset mid-operation aborts it immediately; completed WR/RD strobes are not undone and SC_sp is not restored by this block.

Verification
REQ-035: Check 1 -- SC_sp=FFFF, PUSH wdata0=1234 -> T+1: we=1, addr=FFFF, wdata=1234, sp_inc=1; T+2: done=1, err=0.
REQ-036: Check 2 -- SC_sp=FFFF, POP -> T+1: done=1, err=1, and no we/re/inc/dec at any cycle.
REQ-037: Check 3 -- PUSH2 (AAAA, BBBB) from FFFF, then POP2 -> writes at FFFF and FFFE; reads at FFFE then FFFF; rdata1=BBBB, rdata0=AAAA; done at T+5; SP back at FFFF.
REQ-038: Check 4 -- SC_sp=FF00, PUSH2 -> err=1; SC_sp=FF00, PUSH -> legal, addr=FF00.
REQ-039: Check 5 -- SC_rst asserted at T+2 of a PUSH2 -> next cycle IDLE, ready=1, done=0, exactly one write issued.
REQ-040: Check 6 -- SC_req held high through DONE -> exactly one operation per acceptance, with the next acceptance only after ready=1.
